// File: rtl/tb_mem_latency_model.sv
// Shared imem/dmem model for CPU benches: configurable load latency, multiple
// outstanding loads with response backpressure, byte-strobed stores and HTIF end-of-test detection.
module tb_mem_latency_model #(
  parameter int unsigned MEM_SIZE_WORDS = 16384,
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter int unsigned LOAD_LATENCY   = 1,
  parameter int unsigned RESP_DEPTH     = 4,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        store_err,
  output logic        test_done,
  output logic        test_pass,
  output logic [31:0] test_code,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  localparam int MW = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
  localparam int QW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [32:0]   MEM_BYTES    = 33'(MEM_SIZE_WORDS) << 2;
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(RESP_DEPTH);
  localparam logic [QW-1:0] LAST_SLOT    = QW'(RESP_DEPTH - 1);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } payload_t;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= MEM_BASE) && ({1'b0, a - MEM_BASE} < MEM_BYTES);
  endfunction

  function automatic logic [MW-1:0] word_idx(input logic [31:0] a);
    return MW'((a - MEM_BASE) >> 2);
  endfunction

  function automatic logic [QW-1:0] slot_inc(input logic [QW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] mem [MEM_SIZE_WORDS];

  logic        req_fire, load_fire, store_fire, req_in_range, tohost_hit, pop;
  logic [MW-1:0] req_idx;
  payload_t    load_pl, push_pl;
  logic        push_vld;
  logic [CW-1:0] out_cnt;

  assign req_ready    = (out_cnt < DEPTH_C);
  assign req_fire     = req_valid & req_ready;
  assign load_fire    = req_fire & ~req_we;
  assign store_fire   = req_fire & req_we;
  assign req_in_range = in_range(req_addr);
  assign req_idx      = word_idx(req_addr);
  assign tohost_hit   = store_fire && (req_addr[31:2] == TOHOST_ADDR[31:2]) && (req_wstrb == 4'hF);

  // Load data is captured in the accept cycle so later stores cannot alter it.
  assign load_pl.err  = ~req_in_range;
  assign load_pl.data = req_in_range ? mem[req_idx] : 32'hDEAD_BEEF;

  assign imem_data = in_range(imem_addr) ? mem[word_idx(imem_addr)] : 32'h0;

  // NOTE: the backing store is deliberately not reset so bench preloads survive a reset.
  always_ff @(posedge clock) begin
    if (store_fire && req_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // LOAD_LATENCY-1 register stages; the FIFO write supplies the final cycle of latency.
  generate
    if (LOAD_LATENCY > 1) begin : g_delay
      logic     dl_vld [LOAD_LATENCY-1];
      payload_t dl_pl  [LOAD_LATENCY-1];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < LOAD_LATENCY - 1; i++) begin
            dl_vld[i] <= 1'b0;
            dl_pl[i]  <= '0;
          end
        end else begin
          dl_vld[0] <= load_fire;
          dl_pl[0]  <= load_pl;
          for (int i = 1; i < LOAD_LATENCY - 1; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_pl[i]  <= dl_pl[i-1];
          end
        end
      end

      assign push_vld = dl_vld[LOAD_LATENCY-2];
      assign push_pl  = dl_pl[LOAD_LATENCY-2];
    end else begin : g_direct
      assign push_vld = load_fire;
      assign push_pl  = load_pl;
    end
  endgenerate

  // Response FIFO; out_cnt bounds total in-flight loads so it can never overflow.
  payload_t      q [RESP_DEPTH];
  logic [QW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_cnt;

  assign resp_valid = (q_cnt != '0);
  assign resp_data  = q[rd_ptr].data;
  assign resp_err   = q[rd_ptr].err;
  assign pop        = resp_valid & resp_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RESP_DEPTH; i++) q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push_vld) begin
        q[wr_ptr] <= push_pl;
        wr_ptr    <= slot_inc(wr_ptr);
      end
      if (pop) rd_ptr <= slot_inc(rd_ptr);
      case ({push_vld, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_cnt <= '0;
    end else begin
      case ({load_fire, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Status: HTIF capture, store errors, saturating cycle counter and timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      store_err   <= 1'b0;
      test_done   <= 1'b0;
      test_pass   <= 1'b0;
      test_code   <= '0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (store_fire && !req_in_range) store_err <= 1'b1;
      if (tohost_hit && !test_done) begin
        test_done <= 1'b1;
        test_code <= req_wdata;
        test_pass <= (req_wdata == 32'h1);
      end
      if (!test_done && !tohost_hit && cycle_count == TIMEOUT_LAST) timeout <= 1'b1;
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_tb_mem_latency_model.sv
// Directed bench for tb_mem_latency_model: latency, backpressure, strobes,
// ordering, range/HTIF, reset flush and timeout, with hand-computed expectations.
module tb_tb_mem_latency_model;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic        store_err, test_done, test_pass, timeout;
  logic [31:0] test_code, cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  tb_mem_latency_model #(
    .MEM_SIZE_WORDS(16384),
    .MEM_BASE      (32'h0000_0000),
    .LOAD_LATENCY  (3),
    .RESP_DEPTH    (4),
    .TOHOST_ADDR   (32'h0000_1000),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .store_err  (store_err),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .test_code  (test_code),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds one request until it is accepted (bounded), then drops it.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) check("req_accept_wait", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic [31:0] exp_data, input logic exp_err);
    int n;
    resp_ready = 1'b1;
    n = 0;
    while (!resp_valid && n < 50) begin tick(); n++; end
    if (!resp_valid) begin
      check({tag, "_resp_wait"}, 32'(resp_valid), 32'h1);
    end else begin
      check({tag, "_data"}, resp_data, exp_data);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      tick();
    end
  endtask

  initial begin
    int acc;
    logic seen;
    int n;

    reset = 1'b1; imem_addr = '0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_cycle_count", cycle_count, 32'h0);
    check("rst_flags", {28'h0, store_err, test_done, test_pass, timeout}, 32'h0);

    // Latency 3: accept in cycle T, resp_valid first seen in T+3.
    send(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    check("lat_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    check("lat_t1", 32'(resp_valid), 32'h0);
    tick();
    check("lat_t2", 32'(resp_valid), 32'h0);
    tick();
    check("lat_t3_valid", 32'(resp_valid), 32'h1);
    check("lat_t3_data", resp_data, 32'hCAFE_F00D);
    tick();
    check("lat_popped", 32'(resp_valid), 32'h0);

    // Backpressure: six loads offered with resp_ready low, only four fit.
    for (int i = 0; i < 6; i++) send(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
    resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200 + 32'(4 * acc);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_ready_low", 32'(req_ready), 32'h0);
    for (int c = 0; c < 4; c++) tick();
    check("bp_hold_valid", 32'(resp_valid), 32'h1);
    check("bp_hold_data", resp_data, 32'h1000);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(resp_valid), 32'h1);
      check($sformatf("bp_data%0d", i), resp_data, 32'h1000 + 32'(i));
      tick();
      if (i == 0) check("bp_ready_after_pop", 32'(req_ready), 32'h1);
    end
    check("bp_drained", 32'(resp_valid), 32'h0);

    // Byte strobes, zero-strobe no-op and imem visibility.
    send(1'b1, 32'h40, 32'h1122_3344, 4'hF);
    send(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101);
    send(1'b0, 32'h40, 32'h0, 4'h0);
    wait_resp("strb", 32'h11BB_33DD, 1'b0);
    send(1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0);
    send(1'b0, 32'h40, 32'h0, 4'h0);
    wait_resp("strb_zero", 32'h11BB_33DD, 1'b0);
    imem_addr = 32'h40; #1;
    check("imem_word", imem_data, 32'h11BB_33DD);
    imem_addr = 32'h0010_0000; #1;
    check("imem_oob", imem_data, 32'h0);

    // Ordering: store-then-load sees new data; load-then-store keeps old data.
    send(1'b1, 32'h80, 32'h5, 4'hF);
    send(1'b0, 32'h80, 32'h0, 4'h0);
    wait_resp("ord_st_ld", 32'h5, 1'b0);
    send(1'b0, 32'h80, 32'h0, 4'h0);
    send(1'b1, 32'h80, 32'h9, 4'hF);
    wait_resp("ord_ld_st", 32'h5, 1'b0);
    send(1'b0, 32'h80, 32'h0, 4'h0);
    wait_resp("ord_new", 32'h9, 1'b0);

    // Range errors and HTIF.
    send(1'b0, 32'h0010_0000, 32'h0, 4'h0);
    wait_resp("oob_load", 32'hDEAD_BEEF, 1'b1);
    check("store_err_clear", 32'(store_err), 32'h0);
    send(1'b1, 32'h0010_0000, 32'h1234, 4'hF);
    check("store_err_set", 32'(store_err), 32'h1);
    check("pre_done", 32'(test_done), 32'h0);
    send(1'b1, 32'h1000, 32'h1, 4'hF);
    check("htif_done", 32'(test_done), 32'h1);
    check("htif_pass", 32'(test_pass), 32'h1);
    check("htif_code", test_code, 32'h1);
    send(1'b1, 32'h1000, 32'h3, 4'hF);
    check("htif_code_kept", test_code, 32'h1);
    check("htif_pass_kept", 32'(test_pass), 32'h1);
    send(1'b0, 32'h1000, 32'h0, 4'h0);
    wait_resp("htif_mem", 32'h3, 1'b0);

    // Reset with two loads in flight: nothing comes out afterwards.
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    tick();
    req_addr = 32'h104;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_ready", 32'(req_ready), 32'h1);
    check("flush_cycle0", cycle_count, 32'h0);
    check("flush_done_clr", 32'(test_done), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_resp", 32'(seen), 32'h0);

    // Timeout with no tohost store since reset.
    n = 0;
    while (cycle_count != 32'd49 && n < 100) begin tick(); n++; end
    check("to_reach49", cycle_count, 32'd49);
    check("to_before", 32'(timeout), 32'h0);
    tick();
    check("to_count50", cycle_count, 32'd50);
    check("to_set", 32'(timeout), 32'h1);
    tick();
    check("to_sticky", 32'(timeout), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
